// File: rtl/tl_pkg.sv
// Shared definitions for the two-road traffic-light controller.
//   - tl_state_e : 2-bit state code {Q1,Q0} held in the external state register
//   - L_*        : per-road light codes driven on la / lb
//   - main_light / side_light : pure decodes of state into light codes
package tl_pkg;

    typedef enum logic [1:0] {
        S_MG = 2'b00,  // main green, side red
        S_MY = 2'b01,  // main yellow, side red
        S_SG = 2'b10,  // main red, side green
        S_SY = 2'b11   // main red, side yellow
    } tl_state_e;

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b10;

    function automatic logic [1:0] main_light(tl_state_e s);
        logic [1:0] l;
        l = L_RED;
        unique case (s)
            S_MG:    l = L_GREEN;
            S_MY:    l = L_YELLOW;
            S_SG:    l = L_RED;
            S_SY:    l = L_RED;
        endcase
        return l;
    endfunction

    function automatic logic [1:0] side_light(tl_state_e s);
        logic [1:0] l;
        l = L_RED;
        unique case (s)
            S_MG:    l = L_RED;
            S_MY:    l = L_RED;
            S_SG:    l = L_GREEN;
            S_SY:    l = L_YELLOW;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tl_fsm_ctrl_if.sv
// Sensor / light bundle of the traffic-light controller.
//   ta, tb : vehicle present on main / side road
//   emg    : emergency request (main road to green as soon as safe)
//   la, lb : main / side light codes (00 green, 01 yellow, 10 red)
//   state  : current state {Q1,Q0}
//   dwell  : cycles spent in current state, saturating
// The controller uses the slave modport; the environment drives the master side.
interface tl_fsm_ctrl_if #(
    parameter int unsigned CNT_W = 4
);
    logic             ta;
    logic             tb;
    logic             emg;
    logic [1:0]       la;
    logic [1:0]       lb;
    logic [1:0]       state;
    logic [CNT_W-1:0] dwell;

    modport master (
        output ta, tb, emg,
        input  la, lb, state, dwell
    );

    modport slave (
        input  ta, tb, emg,
        output la, lb, state, dwell
    );
endinterface

// File: rtl/tl_dff_r_async.sv
// Single D flip-flop with asynchronous active-low reset to 0.
//   clk     : rising-edge clock
//   reset_n : asynchronous reset, active-low
//   d / q   : data in / registered out
module tl_dff_r_async (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end
endmodule

// File: rtl/tl_dwell_cnt.sv
// Dwell counter: counts cycles spent in the current state.
//   clk     : rising-edge clock
//   reset_n : asynchronous reset, active-low (count -> 0)
//   clr     : synchronous clear, wins over increment
//   cnt     : current count, saturates at all-ones
module tl_dwell_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt != {CNT_W{1'b1}}) begin
            cnt_d = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_d;
        end
    end
endmodule

// File: rtl/tl_register2_r_async.sv
// Two-bit register built from two async-reset flops; resets to 2'b00.
//   clk     : rising-edge clock
//   reset_n : asynchronous reset, active-low
//   d / q   : 2-bit data in / registered out
module tl_register2_r_async (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] d,
    output logic [1:0] q
);
    tl_dff_r_async u_bit0 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (d[0]),
        .q       (q[0])
    );

    tl_dff_r_async u_bit1 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (d[1]),
        .q       (q[1])
    );
endmodule

// File: rtl/tl_fsm_ctrl.sv
// Two-road traffic-light controller.
// Computes the next state from the sensors and dwell count and is the sole
// writer of the 2-bit state register's D inputs. Lights are pure decodes of
// the registered state, so they change together with state.
//   clk     : rising-edge clock
//   reset_n : asynchronous reset, active-low (state S_MG, dwell 0)
//   bus     : slave side of tl_fsm_ctrl_if (ta/tb/emg in; la/lb/state/dwell out)
module tl_fsm_ctrl
    import tl_pkg::*;
#(
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned GREEN_MIN  = 5,
    parameter int unsigned GREEN_MAX  = 12,
    parameter int unsigned YELLOW_CYC = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    tl_fsm_ctrl_if.slave bus
);
    // Thresholds are "minus one" because dwell reads 0 during the first cycle
    // of a state; leaving on the edge where dwell == N-1 gives N cycles.
    localparam logic [CNT_W-1:0] GreenMinM1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GreenMaxM1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YellowM1   = CNT_W'(YELLOW_CYC - 1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    tl_state_e        state_cur;
    tl_state_e        state_nxt;
    logic [CNT_W-1:0] dwell;
    logic             min_met;
    logic             max_met;
    logic             yel_done;
    logic             dwell_clr;

    assign state_cur = tl_state_e'(state_q);
    assign min_met   = (dwell >= GreenMinM1);
    assign max_met   = (dwell >= GreenMaxM1);
    assign yel_done  = (dwell == YellowM1);

    always_comb begin
        state_nxt = state_cur;
        unique case (state_cur)
            S_MG: begin
                // Emergency pins main green; otherwise yield to side demand
                // once min green is met and main is idle or max green is hit.
                if (min_met && bus.tb && !bus.emg && (!bus.ta || max_met)) begin
                    state_nxt = S_MY;
                end
            end
            S_MY: begin
                if (yel_done) begin
                    state_nxt = S_SG;
                end
            end
            S_SG: begin
                // Emergency bypasses min green to get main road moving.
                if (bus.emg || (min_met && (!bus.tb || (bus.ta && max_met)))) begin
                    state_nxt = S_SY;
                end
            end
            S_SY: begin
                if (yel_done) begin
                    state_nxt = S_MG;
                end
            end
        endcase
    end

    assign state_d   = state_nxt;
    assign dwell_clr = (state_nxt != state_cur);

    tl_register2_r_async u_state_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (state_d),
        .q       (state_q)
    );

    tl_dwell_cnt #(
        .CNT_W (CNT_W)
    ) u_dwell_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (dwell_clr),
        .cnt     (dwell)
    );

    assign bus.state = state_q;
    assign bus.dwell = dwell;
    assign bus.la    = main_light(state_cur);
    assign bus.lb    = side_light(state_cur);
endmodule

// File: tb/tb_tl_fsm_ctrl.sv
// Directed testbench for tl_fsm_ctrl with hand-computed expectations.
module tb_tl_fsm_ctrl;
    localparam int unsigned CNT_W = 4;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;

    tl_fsm_ctrl_if #(.CNT_W(CNT_W)) bus ();

    tl_fsm_ctrl #(
        .CNT_W      (CNT_W),
        .GREEN_MIN  (5),
        .GREEN_MAX  (12),
        .YELLOW_CYC (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Check state, dwell and both lights against the expected state code.
    task automatic check_all(input string tag, input logic [1:0] st, input int dw);
        logic [1:0] ela;
        logic [1:0] elb;
        case (st)
            2'b00:   begin ela = 2'b00; elb = 2'b10; end
            2'b01:   begin ela = 2'b01; elb = 2'b10; end
            2'b10:   begin ela = 2'b10; elb = 2'b00; end
            default: begin ela = 2'b10; elb = 2'b01; end
        endcase
        check_eq({tag, ".state"}, 32'(bus.state), 32'(st));
        check_eq({tag, ".dwell"}, 32'(bus.dwell), 32'(dw));
        check_eq({tag, ".la"}, 32'(bus.la), 32'(ela));
        check_eq({tag, ".lb"}, 32'(bus.lb), 32'(elb));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        bus.ta  = 1'b0;
        bus.tb  = 1'b0;
        bus.emg = 1'b0;
        #2;
        check_all("reset", 2'b00, 0);
        step(1);
        reset_n = 1'b1;

        // Side demand only: MY on edge 5, SG on edge 8.
        bus.tb = 1'b1;
        step(4);
        check_all("mg_d4", 2'b00, 4);
        step(1);
        check_all("my_entry", 2'b01, 0);
        step(2);
        check_all("my_d2", 2'b01, 2);
        step(1);
        check_all("sg_entry", 2'b10, 0);

        // Emergency at SG dwell 1 cuts side green short.
        step(1);
        check_all("sg_d1", 2'b10, 1);
        bus.emg = 1'b1;
        step(1);
        check_all("emg_sy", 2'b11, 0);
        step(2);
        check_all("emg_sy_d2", 2'b11, 2);
        step(1);
        check_all("emg_mg", 2'b00, 0);
        // Emergency held keeps main green despite side demand; dwell saturates.
        step(20);
        check_all("emg_hold", 2'b00, 15);
        bus.emg = 1'b0;
        step(1);
        check_all("emg_rel_my", 2'b01, 0);
        step(3);
        check_all("sg_again", 2'b10, 0);
        bus.tb = 1'b0;
        step(5);
        check_all("sg_notb_sy", 2'b11, 0);
        step(1);
        check_all("sy_d1", 2'b11, 1);
        // Asynchronous reset between edges from a yellow state.
        reset_n = 1'b0;
        #1;
        check_all("async_rst", 2'b00, 0);
        #2;
        reset_n = 1'b1;
        step(1);

        // No demand: hold main green, dwell saturates at 15.
        do_reset();
        bus.ta = 1'b0;
        bus.tb = 1'b0;
        step(40);
        check_all("idle40", 2'b00, 15);

        // Min green: tb pulse at dwell 2 ignored, tb at dwell 4 honoured.
        do_reset();
        step(2);
        check_all("min_d2", 2'b00, 2);
        bus.tb = 1'b1;
        step(1);
        bus.tb = 1'b0;
        check_all("min_pulse", 2'b00, 3);
        step(1);
        check_all("min_d4", 2'b00, 4);
        bus.tb = 1'b1;
        step(1);
        check_all("min_go", 2'b01, 0);
        bus.tb = 1'b0;

        // Both roads demanding: 30-cycle period 12 MG / 3 MY / 12 SG / 3 SY.
        do_reset();
        bus.ta = 1'b1;
        bus.tb = 1'b1;
        for (int k = 0; k < 62; k++) begin
            int         pos;
            logic [1:0] est;
            int         edw;
            pos = k % 30;
            if (pos < 12)      begin est = 2'b00; edw = pos;      end
            else if (pos < 15) begin est = 2'b01; edw = pos - 12; end
            else if (pos < 27) begin est = 2'b10; edw = pos - 15; end
            else               begin est = 2'b11; edw = pos - 27; end
            check_eq("both.state", 32'(bus.state), 32'(est));
            check_eq("both.dwell", 32'(bus.dwell), 32'(edw));
            check_eq("both.safe", 32'((bus.la != 2'b10) && (bus.lb != 2'b10)), 32'd0);
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
